// File: rtl/reg_writeback_bank.sv
// Write side of the 16 x 32-bit register file: single writes and ascending
// register-list bursts over valid/ready. Optional macro WB_PC_PROTECT_EN blocks R15 writes.
module reg_writeback_bank #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_mode,
    input  logic [3:0]        i_addr,
    input  logic [15:0]       i_list,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_R0,
    output logic [DATA_W-1:0] o_R1,
    output logic [DATA_W-1:0] o_R2,
    output logic [DATA_W-1:0] o_R3,
    output logic [DATA_W-1:0] o_R4,
    output logic [DATA_W-1:0] o_R5,
    output logic [DATA_W-1:0] o_R6,
    output logic [DATA_W-1:0] o_R7,
    output logic [DATA_W-1:0] o_R8,
    output logic [DATA_W-1:0] o_R9,
    output logic [DATA_W-1:0] o_R10,
    output logic [DATA_W-1:0] o_R11,
    output logic [DATA_W-1:0] o_R12,
    output logic [DATA_W-1:0] o_R13,
    output logic [DATA_W-1:0] o_R14,
    output logic [DATA_W-1:0] o_R15,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pc_wr
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [15:0]       mask_q, mask_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic              done_p1, pc_wr_p1;

    logic              accept;
    logic [15:0]       src_mask;
    logic [15:0]       rem_mask;
    logic [3:0]        wr_idx;
    logic              wr_en;
    logic              done_d, pc_wr_d;

    function automatic logic [3:0] lowest_idx(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    assign o_ready = i_rst_n;
    assign accept  = i_valid && o_ready;

    // A single write is treated as a one-bit list so both modes share the walker.
    always_comb begin
        src_mask = 16'h0000;
        if (state_q == BURST)  src_mask = mask_q;
        else if (i_mode)       src_mask = i_list;
        else                   src_mask = 16'h0001 << i_addr;
    end

    assign wr_idx   = lowest_idx(src_mask);
    assign rem_mask = src_mask & ~(16'h0001 << wr_idx);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        pc_wr_d = 1'b0;
        wr_en   = 1'b0;
        if (accept) begin
            mask_d  = rem_mask;
            done_d  = (rem_mask == 16'h0000);
            state_d = (rem_mask == 16'h0000) ? IDLE : BURST;
`ifdef WB_PC_PROTECT_EN
            wr_en   = (src_mask != 16'h0000) && (wr_idx != 4'd15);
`else
            wr_en   = (src_mask != 16'h0000);
            pc_wr_d = (src_mask != 16'h0000) && (wr_idx == 4'd15);
`endif
        end
    end

    // Stage p1: control state and one-cycle status pulses
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            mask_q   <= 16'h0000;
            done_p1  <= 1'b0;
            pc_wr_p1 <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            done_p1  <= done_d;
            pc_wr_p1 <= pc_wr_d;
        end
    end

    // Register contents are architecturally cleared by reset, unlike pure datapath.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[wr_idx] <= i_data;
        end
    end

    assign o_busy  = (state_q == BURST);
    assign o_done  = done_p1;
    assign o_pc_wr = pc_wr_p1;

    assign o_R0  = regs_q[0];
    assign o_R1  = regs_q[1];
    assign o_R2  = regs_q[2];
    assign o_R3  = regs_q[3];
    assign o_R4  = regs_q[4];
    assign o_R5  = regs_q[5];
    assign o_R6  = regs_q[6];
    assign o_R7  = regs_q[7];
    assign o_R8  = regs_q[8];
    assign o_R9  = regs_q[9];
    assign o_R10 = regs_q[10];
    assign o_R11 = regs_q[11];
    assign o_R12 = regs_q[12];
    assign o_R13 = regs_q[13];
    assign o_R14 = regs_q[14];
    assign o_R15 = regs_q[15];

endmodule

// File: tb/tb_reg_writeback_bank.sv
// Directed table-driven bench for reg_writeback_bank plus a reset-mid-burst sequence.
module tb_reg_writeback_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic        mode;
    logic [3:0]  addr;
    logic [15:0] list;
    logic [31:0] data;
    logic        busy, done, pc_wr;
    logic [31:0] r [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_writeback_bank #(.DATA_W(32), .NREG(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
        .i_mode(mode), .i_addr(addr), .i_list(list), .i_data(data),
        .o_R0(r[0]), .o_R1(r[1]), .o_R2(r[2]), .o_R3(r[3]),
        .o_R4(r[4]), .o_R5(r[5]), .o_R6(r[6]), .o_R7(r[7]),
        .o_R8(r[8]), .o_R9(r[9]), .o_R10(r[10]), .o_R11(r[11]),
        .o_R12(r[12]), .o_R13(r[13]), .o_R14(r[14]), .o_R15(r[15]),
        .o_busy(busy), .o_done(done), .o_pc_wr(pc_wr)
    );

    typedef struct {
        logic        v;
        logic        m;
        logic [3:0]  a;
        logic [15:0] l;
        logic [31:0] d;
        logic        e_done;
        logic        e_busy;
        logic        e_pc;
        logic [3:0]  chk_reg;
        logic [31:0] e_val;
    } vec_t;

    vec_t vec [13];

`ifdef WB_PC_PROTECT_EN
    localparam logic        PC_PULSE = 1'b0;
    localparam logic [31:0] R15_A    = 32'h0;
    localparam logic [31:0] R15_B    = 32'h0;
`else
    localparam logic        PC_PULSE = 1'b1;
    localparam logic [31:0] R15_A    = 32'h22;
    localparam logic [31:0] R15_B    = 32'h33;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_R%0d", name, i), r[i], 32'h0);
    endtask

    task automatic drive(input logic v, input logic m, input logic [3:0] a,
                         input logic [15:0] l, input logic [31:0] d);
        valid = v; mode = m; addr = a; list = l; data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec[0]  = '{1'b1, 1'b0, 4'd5, 16'h0000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4'd5, 32'hDEADBEEF};
        vec[1]  = '{1'b0, 1'b0, 4'd4, 16'h0000, 32'h12345678, 1'b0, 1'b0, 1'b0, 4'd4, 32'h0};
        vec[2]  = '{1'b1, 1'b1, 4'd0, 16'h0092, 32'hAAAA0001, 1'b0, 1'b1, 1'b0, 4'd1, 32'hAAAA0001};
        vec[3]  = '{1'b0, 1'b0, 4'd3, 16'hFFFF, 32'hBAD00000, 1'b0, 1'b1, 1'b0, 4'd4, 32'h0};
        vec[4]  = '{1'b0, 1'b1, 4'd9, 16'h0001, 32'hBAD00001, 1'b0, 1'b1, 1'b0, 4'd5, 32'hDEADBEEF};
        vec[5]  = '{1'b1, 1'b0, 4'd9, 16'h0200, 32'hAAAA0002, 1'b0, 1'b1, 1'b0, 4'd4, 32'hAAAA0002};
        vec[6]  = '{1'b1, 1'b1, 4'd9, 16'h0200, 32'hAAAA0003, 1'b1, 1'b0, 1'b0, 4'd7, 32'hAAAA0003};
        vec[7]  = '{1'b1, 1'b1, 4'd0, 16'h0000, 32'h55555555, 1'b1, 1'b0, 1'b0, 4'd9, 32'h0};
        vec[8]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vec[9]  = '{1'b1, 1'b1, 4'd0, 16'h8001, 32'h11, 1'b0, 1'b1, 1'b0, 4'd0, 32'h11};
        vec[10] = '{1'b1, 1'b0, 4'd3, 16'h0000, 32'h22, 1'b1, 1'b0, PC_PULSE, 4'd15, R15_A};
        vec[11] = '{1'b0, 1'b0, 4'd0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 4'd1, 32'hAAAA0001};
        vec[12] = '{1'b1, 1'b0, 4'd15, 16'h0000, 32'h33, 1'b1, 1'b0, PC_PULSE, 4'd15, R15_B};

        rst_n = 1'b0;
        valid = 1'b0; mode = 1'b0; addr = 4'd0; list = 16'h0; data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk_all_zero("rst");
        chk("rst_ready_hi", {31'b0, ready}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_pc_wr", {31'b0, pc_wr}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            drive(vec[i].v, vec[i].m, vec[i].a, vec[i].l, vec[i].d);
            chk($sformatf("v%0d_done", i), {31'b0, done}, {31'b0, vec[i].e_done});
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vec[i].e_busy});
            chk($sformatf("v%0d_pc_wr", i), {31'b0, pc_wr}, {31'b0, vec[i].e_pc});
            chk($sformatf("v%0d_ready", i), {31'b0, ready}, 32'h1);
            chk($sformatf("v%0d_R%0d", i, vec[i].chk_reg), r[vec[i].chk_reg], vec[i].e_val);
        end
        // Burst registers retain their values after later operations.
        chk("hold_R4", r[4], 32'hAAAA0002);
        chk("hold_R7", r[7], 32'hAAAA0003);
        chk("hold_R5", r[5], 32'hDEADBEEF);
        chk("hold_R0", r[0], 32'h11);
        chk("hold_R3", r[3], 32'h0);

        // Reset in the middle of a four-register burst.
        drive(1'b1, 1'b1, 4'd0, 16'h000F, 32'h1);
        drive(1'b1, 1'b0, 4'd0, 16'h0000, 32'h2);
        chk("mb_busy", {31'b0, busy}, 32'h1);
        chk("mb_R1", r[1], 32'h2);
        valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk_all_zero("mbrst");
        chk("mbrst_busy", {31'b0, busy}, 32'h0);
        chk("mbrst_done", {31'b0, done}, 32'h0);
        drive(1'b1, 1'b0, 4'd2, 16'h0000, 32'h7);
        chk("post_R2", r[2], 32'h7);
        chk("post_R3", r[3], 32'h0);
        chk("post_done", {31'b0, done}, 32'h1);
        chk("post_busy", {31'b0, busy}, 32'h0);
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 32'h0);
        chk("post_done_clr", {31'b0, done}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_writeback_bank.md
Name: reg_writeback_bank

Overview:
- Write side of the 16 x 32-bit general register file.
- Takes ALU or load results over a valid/ready handshake and writes them into R0..R15. Supports single-register writes and ascending register-list bursts (LDM-style).
- Drives all 16 register values in parallel so the operand-select muxes can read them.
- Sits between execute/memory writeback and the operand selection stage.

Parameters:
- DATA_W, 32, register width.
- NREG, 16, register count; fixed at 16 because addresses and the list are 4/16 bits.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  write beat valid.
- o_ready  output  1  beat can be accepted this cycle.
- i_mode  input  1  0 = single write, 1 = list burst; sampled only on the first beat.
- i_addr  input  4  target register for a single write.
- i_list  input  16  register list for a burst; bit n selects Rn; sampled only on the first beat.
- i_data  input  DATA_W  write data.
- o_R0..o_R15  output  DATA_W each  current register contents.
- o_busy  output  1  burst in progress.
- o_done  output  1  one-cycle pulse, the cycle after the final write of an operation.
- o_pc_wr  output  1  one-cycle pulse, the cycle after R15 is written.

Behaviour:
- Reset, on the i_clk edge with i_rst_n=0: all o_Rn=0, state IDLE, o_busy=0, o_done=0, o_pc_wr=0.
- Reset mid-burst abandons the burst. Registers already written are also cleared to 0.
- Handshake:
  - beat accepted when i_valid && o_ready at a rising edge.
  - o_ready = 1 in IDLE and in BURST; it is 0 only during reset.
  - i_data must be held while i_valid=1 and o_ready=0.
- Write latency: the register updates on the accepting edge; new value visible on o_Rn the following cycle. No read-during-write bypass.
- States: IDLE, BURST.
- IDLE, single write (i_mode=0):
  - beat writes Rn with n=i_addr.
  - o_done=1 next cycle.
  - stays IDLE.
- IDLE, burst (i_mode=1, i_list!=0):
  - i_list latched into pending mask.
  - first beat writes the lowest set bit's register; that bit is cleared from the mask.
  - if the mask is now empty: o_done next cycle, stay IDLE.
  - else go to BURST, o_busy=1.
- IDLE, empty burst (i_mode=1, i_list=0): beat accepted, no register written, o_done=1 next cycle.
- BURST:
  - each accepted beat writes the lowest set bit of the mask and clears it.
  - i_mode, i_addr, i_list are ignored.
  - when the last bit is cleared: next state IDLE, o_busy=0, o_done=1.
  - no beat (i_valid=0): hold state and mask.
- Beat count of a burst = popcount(i_list). Order is strictly ascending register number.
- o_pc_wr pulses once per R15 write; in a burst this is always the last beat.
- Back-to-back: a new operation may be accepted in the same cycle that o_done is high.

Optional Feature:
- Macro: WB_PC_PROTECT_EN.
- Defined:
  - writes to R15 are discarded; R15 holds its value.
  - o_pc_wr stays 0.
  - in a burst the beat still consumes the R15 list bit and still counts toward completion.
- Undefined: R15 is written like any other register, with o_pc_wr as described.

Test Plan:
- Reset, then check idle outputs -> all o_R0..o_R15=0, o_ready=1, o_busy=0.
- Single write: i_mode=0, i_addr=5, i_data=32'hDEADBEEF -> o_R5=DEADBEEF next cycle, o_done pulse, all other registers unchanged.
- Burst: i_list=16'h0092, beats AAAA0001/2/3 with a 2-cycle i_valid gap after beat 1 -> R1=..01, R4=..02, R7=..03; o_busy high through the gap; o_done one cycle after beat 3.
- Empty list: i_mode=1, i_list=0 -> no register change, o_done next cycle, o_busy stays 0.
- R15 burst: i_list=16'h8001, data 11, 22 -> R0=11, R15=22, o_pc_wr pulse with o_done. With WB_PC_PROTECT_EN defined: R15 unchanged, o_pc_wr=0, o_done still pulses.
- Reset mid-burst: i_list=16'h000F, two beats, then i_rst_n=0 for one cycle -> all registers 0, state IDLE. The next single write to R2=7 behaves normally.
